pixel_distributor: RTL and testbench

//  Frame-level scheduler feeding the render engines. It walks the screen in raster order and hands
//  one (x,y) coordinate at a time to an idle engine, choosing engines round-robin. An engine is

---
 rtl/pixel_distributor.sv | 162 ++++++++++++++++
 tb/tb_pixel_distributor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_distributor.sv
// Raster-order pixel scheduler: round-robin dispatch of (x,y) to engines.
// Optional stall counter enabled by defining DIST_STALL_CNT_EN.
module pixel_distributor #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENGINES = 4,
  parameter int ENG_IDX_W   = 2,
  parameter int X_RES       = 640,
  parameter int Y_RES       = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_ENGINES-1:0] engine_ready,
  input  logic [NUM_ENGINES-1:0] full_queue,
  output logic [NUM_ENGINES-1:0] dispatch_o,
  output logic [DATA_WIDTH-1:0]  xpixel_o,
  output logic [DATA_WIDTH-1:0]  ypixel_o,
  output logic                   busy,
  output logic                   done
`ifdef DIST_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [DATA_WIDTH-1:0] X_MAX = DATA_WIDTH'(X_RES - 1);
  localparam logic [DATA_WIDTH-1:0] Y_MAX = DATA_WIDTH'(Y_RES - 1);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d;
  logic [DATA_WIDTH-1:0]  y_q, y_d;
  logic [ENG_IDX_W-1:0]   rr_q, rr_d;
  logic                   last_q, last_d;
  logic [NUM_ENGINES-1:0] dispatch_q, dispatch_d;
  logic [DATA_WIDTH-1:0]  xpix_q, xpix_d;
  logic [DATA_WIDTH-1:0]  ypix_q, ypix_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [NUM_ENGINES-1:0] elig;
  logic                   found;
  logic [ENG_IDX_W-1:0]   gnt_idx;
  int                     idx;

  // dispatch_q is exactly the one-hot of last cycle's grant, so it is the mask
  assign elig = engine_ready & ~full_queue & ~dispatch_q;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      idx = (int'(rr_q) + k) % NUM_ENGINES;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = ENG_IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    rr_d       = rr_q;
    last_d     = last_q;
    dispatch_d = '0;
    xpix_d     = xpix_q;
    ypix_d     = ypix_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          last_d  = 1'b0;
        end
      end
      SCAN: begin
        // last_q: final pixel already on the outputs, close the frame
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
        end else if (found) begin
          dispatch_d[gnt_idx] = 1'b1;
          xpix_d = x_q;
          ypix_d = y_q;
          rr_d   = ENG_IDX_W'((int'(gnt_idx) + 1) % NUM_ENGINES);
          if (x_q == X_MAX) begin
            x_d = '0;
            if (y_q == Y_MAX) last_d = 1'b1;
            else              y_d    = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      rr_q       <= '0;
      last_q     <= 1'b0;
      dispatch_q <= '0;
      xpix_q     <= '0;
      ypix_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rr_q       <= rr_d;
      last_q     <= last_d;
      dispatch_q <= dispatch_d;
      xpix_q     <= xpix_d;
      ypix_q     <= ypix_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dispatch_o = dispatch_q;
  assign xpixel_o   = xpix_q;
  assign ypixel_o   = ypix_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef DIST_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start)
      stall_d = '0;
    else if (state_q == SCAN && !last_q && !found && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pixel_distributor.sv
// Scoreboard bench for pixel_distributor on a 4x2 frame with 4 engines.
// Stall counter checks are active when DIST_STALL_CNT_EN is defined.
module tb_pixel_distributor;
  localparam int DW = 32;
  localparam int NE = 4;
  localparam int XR = 4;
  localparam int YR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NE-1:0] engine_ready;
  logic [NE-1:0] full_queue;
  logic [NE-1:0] dispatch_o;
  logic [DW-1:0] xpixel_o;
  logic [DW-1:0] ypixel_o;
  logic          busy;
  logic          done;
`ifdef DIST_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  pixel_distributor #(
    .DATA_WIDTH(DW), .NUM_ENGINES(NE), .ENG_IDX_W(2),
    .X_RES(XR), .Y_RES(YR)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .engine_ready(engine_ready), .full_queue(full_queue),
    .dispatch_o(dispatch_o), .xpixel_o(xpixel_o), .ypixel_o(ypixel_o),
    .busy(busy), .done(done)
`ifdef DIST_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NE-1:0] eng;
    int            x;
    int            y;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   disp_cyc[$];
  int   done_cyc;
  int   done_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  always @(negedge clk) begin
    if (dispatch_o != '0) begin
      disp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("extra_disp", dispatch_o, 0);
      end else begin
        e = exp_q.pop_front();
        chk("disp_eng", dispatch_o, e.eng);
        chk("disp_x", xpixel_o, e.x);
        chk("disp_y", ypixel_o, e.y);
      end
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      chk("busy_at_done", busy, 1);
    end
  end

  task automatic push_n(input int engs[8], input int n);
    exp_t t;
    for (int i = 0; i < n; i++) begin
      t.eng = NE'(1 << engs[i]);
      t.x   = i % XR;
      t.y   = i / XR;
      exp_q.push_back(t);
    end
  endtask

  task automatic begin_frame(input int engs[8]);
    disp_cyc.delete();
    done_n = 0;
    push_n(engs, 8);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic end_frame(input string tag);
    repeat (10) @(negedge clk);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_n_disp"}, disp_cyc.size(), 8);
    chk({tag, "_n_done"}, done_n, 1);
    chk({tag, "_done_lat"}, done_cyc - disp_cyc[$], 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  function automatic int gaps_not(input int g);
    int n = 0;
    for (int i = 1; i < disp_cyc.size(); i++)
      if (disp_cyc[i] - disp_cyc[i-1] != g) n++;
    return n;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_disp"}, dispatch_o, 0);
    chk({tag, "_x"}, xpixel_o, 0);
    chk({tag, "_y"}, ypixel_o, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef DIST_STALL_CNT_EN
    chk({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    start        = 1'b0;
    engine_ready = 4'b1111;
    full_queue   = 4'b0000;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("idle");

    // all engines eligible: round-robin, one pixel per cycle
    begin_frame('{0, 1, 2, 3, 0, 1, 2, 3});
    pulse_start("t1");
    wait_done("t1");
    chk("t1_gaps", gaps_not(1), 0);
    end_frame("t1");

    // engine 1 full: skipped
    full_queue = 4'b0010;
    begin_frame('{0, 2, 3, 0, 2, 3, 0, 2});
    pulse_start("t2");
    wait_done("t2");
    end_frame("t2");
    full_queue = 4'b0000;

    // single engine: masked every other cycle
    engine_ready = 4'b0100;
    begin_frame('{2, 2, 2, 2, 2, 2, 2, 2});
    pulse_start("t3");
    wait_done("t3");
`ifdef DIST_STALL_CNT_EN
    chk("t3_stall", stall_cnt, 7);
`endif
    chk("t3_gaps", gaps_not(2), 0);
    end_frame("t3");
    engine_ready = 4'b1111;

    // no engine ready for 5 cycles right before (2,0); rr_ptr enters at 3
    begin_frame('{3, 0, 1, 2, 3, 0, 1, 2});
    pulse_start("t4");
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (dispatch_o != '0 && xpixel_o == 1) begin
        n = 1;
        break;
      end
      @(negedge clk);
    end
    chk("t4_found_1_0", n, 1);
    engine_ready = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_disp", dispatch_o, 0);
      chk("t4_hold_x", xpixel_o, 1);
    end
    engine_ready = 4'b1111;
    wait_done("t4");
`ifdef DIST_STALL_CNT_EN
    chk("t4_stall", stall_cnt, 5);
`endif
    chk("t4_resume_gap", disp_cyc[2] - disp_cyc[1], 6);
    end_frame("t4");

    // reset after 3 dispatches aborts the frame
    disp_cyc.delete();
    done_n = 0;
    push_n('{3, 0, 1, 0, 0, 0, 0, 0}, 3);
    pulse_start("t5");
    n = 0;
    for (int i = 0; i < 50 && n < 3; i++) begin
      @(negedge clk);
      if (dispatch_o != '0) n++;
    end
    chk("t5_three", n, 3);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("t5_rst");
    chk("t5_q_empty", exp_q.size(), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_no_done", done_n, 0);
    chk("t5_no_disp", disp_cyc.size(), 3);
    begin_frame('{0, 1, 2, 3, 0, 1, 2, 3});
    pulse_start("t5b");
    wait_done("t5b");
    end_frame("t5b");

    // second start mid-frame is ignored
    begin_frame('{0, 1, 2, 3, 0, 1, 2, 3});
    pulse_start("t6");
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("t6");
    end_frame("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
